// File: rtl/alu_misr_checker.sv
// alu_misr_checker
// Compacts a run of 32-bit ALU result vectors into a MISR signature and
// compares the final signature against a golden value latched at start.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   abort             (only with MISR_ABORT_EN) cancel a run in RUN/CHECK
//   start             one-cycle run request (accepted in IDLE or DONE)
//   num_vec[15:0]     vectors in the run, latched on accepted start
//   golden[31:0]      expected final signature, latched on accepted start
//   in_valid, in_data ALU result vector, accepted when in_ready is high
//   in_ready          high only in RUN
//   busy              high in RUN and CHECK
//   done, pass        run complete / final signature matched golden
//   signature[31:0]   current MISR contents
//   vec_count[15:0]   vectors accepted in the current run
//
// Configuration macro: MISR_ABORT_EN adds the abort input and its logic.

module alu_misr_checker #(
    parameter logic [31:0] POLY = 32'h04C11DB7,
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MISR_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic [15:0] num_vec,
    input  logic [31:0] golden,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [15:0] vec_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] num_vec_q;
    logic [31:0] golden_q;

    logic        abort_req;
    logic [31:0] misr_next;
    logic [15:0] count_next;

`ifdef MISR_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // One MISR step: shift, conditional polynomial feedback, fold in the vector
    assign misr_next  = {signature[30:0], 1'b0}
                      ^ (signature[31] ? POLY : 32'h0000_0000)
                      ^ in_data;
    assign count_next = vec_count + 16'd1;

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= SEED;
            vec_count <= 16'd0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            num_vec_q <= 16'd0;
            golden_q  <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        signature <= SEED;
                        vec_count <= 16'd0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        num_vec_q <= num_vec;
                        golden_q  <= golden;
                        busy      <= 1'b1;
                        // An empty run goes straight to the compare
                        if (num_vec != 16'd0) begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= CHECK;
                            in_ready <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (abort_req) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end else if (in_valid) begin
                        signature <= misr_next;
                        vec_count <= count_next;
                        // Last vector: drop ready together with the move to CHECK
                        if (count_next == num_vec_q) begin
                            state    <= CHECK;
                            in_ready <= 1'b0;
                        end
                    end
                end

                CHECK: begin
                    if (abort_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        pass  <= (signature == golden_q);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_misr_checker.sv
// Self-checking bench for alu_misr_checker: directed runs, with a scoreboard
// queue of expected completions checked by an independent monitor on done.
module tb_alu_misr_checker;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        start;
    logic [15:0] num_vec;
    logic [31:0] golden;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        pass;
        logic [31:0] sig;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_misr_checker #(.POLY(POLY), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MISR_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .num_vec   (num_vec),
        .golden    (golden),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_count (vec_count)
    );

    // Reference MISR step
    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        r = {s[30:0], 1'b0} ^ d;
        if (s[31]) r = r ^ POLY;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: each rising edge of done must match the oldest expectation
    initial begin
        logic done_d;
        exp_t e;
        done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done && !done_d) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done=1 sig=%h expected no completion", signature);
                end else begin
                    e = exp_q.pop_front();
                    if (pass !== e.pass || signature !== e.sig || vec_count !== e.cnt) begin
                        failures++;
                        $display("FAIL sb_result: got pass=%b sig=%h cnt=%0d expected pass=%b sig=%h cnt=%0d",
                                 pass, signature, vec_count, e.pass, e.sig, e.cnt);
                    end
                end
            end
            done_d = done;
        end
    end

    task automatic do_start(input logic [15:0] n, input logic [31:0] g);
        @(negedge clk);
        start = 1'b1; num_vec = n; golden = g;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] d);
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] held;
        int          rdy_seen;
        int          t;
        rst_n = 1'b0; abort = 1'b0; start = 1'b0; num_vec = '0; golden = '0;
        in_valid = 1'b0; in_data = '0;

        // Reset state
        #12;
        chk("rst_sig",   signature, SEED);
        chk("rst_cnt",   {16'd0, vec_count}, 32'd0);
        chk("rst_flags", {28'd0, in_ready, busy, done, pass}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // One zero vector, matching golden
        exp_q.push_back('{1'b1, 32'hFB3EE249, 16'd1});
        do_start(16'd1, 32'hFB3EE249);
        chk("start_busy", {30'd0, busy, in_ready}, 32'd3);
        send_vec(32'h0);
        chk("check_phase", {29'd0, in_ready, busy, done}, 32'd2);
        chk("sig_one",    signature, 32'hFB3EE249);
        @(negedge clk);
        chk("done_one",   {30'd0, done, pass}, 32'd3);

        // Same run, wrong golden; restart from DONE clears done/pass
        exp_q.push_back('{1'b0, 32'hFB3EE249, 16'd1});
        do_start(16'd1, 32'h0);
        chk("restart_clr", {30'd0, done, pass}, 32'd0);
        chk("restart_seed", signature, SEED);
        send_vec(32'h0);
        wait_done();

        // Empty run: no ready, done two edges after start
        exp_q.push_back('{1'b1, SEED, 16'd0});
        do_start(16'd0, 32'hFFFFFFFF);
        chk("empty_ready", {30'd0, in_ready, done}, 32'd0);
        @(negedge clk);
        chk("empty_done", {30'd0, done, pass}, 32'd3);

        // Four vectors with gaps and an ignored mid-run start
        s = SEED;
        s = misr(s, 32'h1); s = misr(s, 32'h2); s = misr(s, 32'h3); s = misr(s, 32'h4);
        exp_q.push_back('{1'b1, s, 16'd4});
        do_start(16'd4, s);
        send_vec(32'h1);
        send_vec(32'h2);
        start = 1'b1; num_vec = 16'd0; golden = 32'h0;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_cnt", {16'd0, vec_count}, 32'd2);
        chk("ign_start_st",  {29'd0, in_ready, busy, done}, 32'd6);
        send_vec(32'h3);
        chk("not_done_3", {31'd0, done}, 32'd0);
        send_vec(32'h4);
        wait_done();

        // in_valid in DONE has no effect; DONE outputs hold
        held = s;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done_hold_sig", signature, held);
        chk("done_hold_cnt", {16'd0, vec_count}, 32'd4);
        chk("done_hold_flg", {29'd0, in_ready, done, pass}, 32'd3);

        // Two zero vectors: hand-computed signature
        exp_q.push_back('{1'b1, 32'hF2BCD925, 16'd2});
        do_start(16'd2, 32'hF2BCD925);
        send_vec(32'h0);
        send_vec(32'h0);
        wait_done();

        // Reset in the middle of a run: async clear, no completion
        do_start(16'd4, 32'h0);
        send_vec(32'hA5A5A5A5);
        send_vec(32'h5A5A5A5A);
        chk("pre_rst_cnt", {16'd0, vec_count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig",   signature, SEED);
        chk("arst_cnt",   {16'd0, vec_count}, 32'd0);
        chk("arst_flags", {28'd0, in_ready, busy, done, pass}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{1'b1, 32'hF2BCD925, 16'd2});
        do_start(16'd2, 32'hF2BCD925);
        send_vec(32'h0);
        send_vec(32'h0);
        wait_done();

        // Longer run through the model; ready must drop right after the last vector
        s = SEED;
        for (int i = 0; i < 20; i++) s = misr(s, 32'h1000_0000 * 32'(i) + 32'(i));
        exp_q.push_back('{1'b0, s, 16'd20});
        do_start(16'd20, ~s);
        for (int i = 0; i < 20; i++) send_vec(32'h1000_0000 * 32'(i) + 32'(i));
        chk("long_ready_off", {31'd0, in_ready}, 32'd0);
        wait_done();

`ifdef MISR_ABORT_EN
        // Abort with a vector offered: vector dropped, back to IDLE
        do_start(16'd4, 32'h0);
        send_vec(32'h1);
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_data = 32'h2;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_flags", {28'd0, in_ready, busy, done, pass}, 32'd0);
        chk("abort_cnt",   {16'd0, vec_count}, 32'd1);
        chk("abort_sig",   signature, misr(SEED, 32'h1));
        repeat (3) @(negedge clk);
        chk("abort_nodone", {31'd0, done}, 32'd0);
`endif

        // Idle check: in_ready stays low outside a run
        rdy_seen = 0;
        for (t = 0; t < 4; t++) begin
            @(negedge clk);
            if (in_ready) rdy_seen++;
        end
        chk("idle_ready", 32'(rdy_seen), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the run never completes
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
